// File: rtl/apb_master_bridge_if.sv
// APB3/APB4 bus bundle between the bridge (master) and the periphery slave port.
interface apb_master_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [2:0]      pprot;
    logic            psel;
    logic            penable;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    modport master (
        output paddr, pwrite, pwdata, pstrb, pprot, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, pwdata, pstrb, pprot, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding req/gnt to APB master bridge with address-window check,
// PREADY timeout and a registered one-cycle response.
module apb_master_bridge #(
    parameter int              APB_AW         = 32,
    parameter int              APB_DW         = 32,
    parameter longint unsigned PERIPH_BA      = 0,
    parameter longint unsigned PERIPH_SIZE    = 'h2000,
    parameter int              TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [APB_AW-1:0]     req_addr_i,
    input  logic                  req_we_i,
    input  logic [APB_DW/8-1:0]   req_be_i,
    input  logic [APB_DW-1:0]     req_wdata_i,
    output logic                  rvalid_o,
    output logic [APB_DW-1:0]     rdata_o,
    output logic                  err_o,
    apb_master_bridge_if.master   m_apb
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t                r_state;
    state_t                w_next;
    logic [APB_AW-1:0]     r_addr;
    logic                  r_we;
    logic [APB_DW-1:0]     r_wdata;
    logic [APB_DW/8-1:0]   r_strb;
    logic [APB_DW-1:0]     r_rdata;
    logic                  r_err;
    logic [CNT_W-1:0]      r_cnt;

    logic [APB_AW-1:0]     w_addrAligned;
    logic [63:0]           w_addr64;
    logic                  w_inWin;
    logic                  w_accept;
    logic                  w_timeout;

    // Window check in 64 bits so a window ending at the top of the address space cannot wrap.
    assign w_addrAligned = req_addr_i & ~APB_AW'(3);
    assign w_addr64      = 64'(w_addrAligned);
    assign w_inWin       = (w_addr64 >= PERIPH_BA) && ((w_addr64 - PERIPH_BA) < PERIPH_SIZE);

    assign gnt_o     = (r_state == IDLE) && !prst;
    assign w_accept  = req_i && gnt_o;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    always_comb begin
        w_next          = r_state;
        m_apb.psel      = 1'b0;
        m_apb.penable   = 1'b0;
        rvalid_o        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = w_inWin ? SETUP : RESP;
            end
            SETUP: begin
                m_apb.psel = 1'b1;
                w_next     = ACCESS;
            end
            ACCESS: begin
                m_apb.psel    = 1'b1;
                m_apb.penable = 1'b1;
                if (m_apb.pready || w_timeout) w_next = RESP;
            end
            RESP: begin
                rvalid_o = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign m_apb.paddr  = r_addr;
    assign m_apb.pwrite = r_we;
    assign m_apb.pwdata = r_wdata;
    assign m_apb.pstrb  = r_strb;
    assign m_apb.pprot  = 3'b000;
    assign rdata_o      = r_rdata;
    assign err_o        = r_err;

    // Response data only changes when a response is produced, so it holds between pulses.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= w_addrAligned;
                r_we    <= req_we_i;
                r_wdata <= req_wdata_i;
                r_strb  <= req_we_i ? req_be_i : '0;
                if (!w_inWin) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == ACCESS) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (m_apb.pready) begin
                    r_rdata <= (r_we || m_apb.pslverr) ? '0 : m_apb.prdata;
                    r_err   <= m_apb.pslverr;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == RESP) r_cnt <= '0;
        end
    end
endmodule
